// File: rtl/ppu_scanout.sv
// ppu_scanout: 640x480 video timing generator and display-side reader of the
// PPU row RAM / palette RAM. Shows the 320x240 game image doubled 2x in both
// directions and paces ppu_logic one game row ahead with rowram_swap/next_row.
module ppu_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  hdmi_rowram_rdaddr,
  input  logic [9:0]  hdmi_rowram_rddata,
  output logic [8:0]  hdmi_palram_rdaddr,
  input  logic [63:0] hdmi_palram_rddata,
  output logic        rowram_swap,
  output logic [7:0]  next_row,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        vblank_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_PRE_LAST = CW'(H_TOTAL - 2);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_SWAP_MAX = CW'(V_ACTIVE - 3);
  localparam logic [CW-1:0] V_ROW0     = CW'(V_TOTAL - 3);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]    LAST_ROW   = 8'(V_ACTIVE / 2 - 1);

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;
  logic [7:0]    odd_next_c;
  logic [23:0]   colour_c;
  logic          unused_pal_bits;

  // Pipeline stages behind the counter position (d1 = t+1, d2 = t+2)
  logic act_d1, act_d2;
  logic hs_d1, hs_d2;
  logic vs_d1, vs_d2;
  logic sel_d2;

  // Raster position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Position decode, RAM addressing and palette half select
  always_comb begin
    active_c   = (h < H_ACT) && (v < V_ACT);
    hs_c       = !((h >= HS_START) && (h < HS_END));
    vs_c       = !((v >= VS_START) && (v < VS_END));
    // Odd line v shows row (v+1)/2; the PPU then renders the row after it.
    // The last active swap would name a row past the image, so saturate.
    odd_next_c = 8'(v[CW-1:1]) + 8'd2;
    if (odd_next_c > LAST_ROW) odd_next_c = LAST_ROW;
    colour_c   = sel_d2 ? hdmi_palram_rddata[55:32] : hdmi_palram_rddata[23:0];
  end

  assign hdmi_rowram_rdaddr = active_c ? h[CW-1:1] : '0;
  assign hdmi_palram_rdaddr = hdmi_rowram_rddata[9:1];
  assign unused_pal_bits    = ^{hdmi_palram_rddata[63:56], hdmi_palram_rddata[31:24]};

  // Delay line keeping sync/enable aligned with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_d1 <= 1'b0;
      act_d2 <= 1'b0;
      hs_d1  <= 1'b1;
      hs_d2  <= 1'b1;
      vs_d1  <= 1'b1;
      vs_d2  <= 1'b1;
      sel_d2 <= 1'b0;
    end else begin
      act_d1 <= active_c;
      act_d2 <= act_d1;
      hs_d1  <= hs_c;
      hs_d2  <= hs_d1;
      vs_d1  <= vs_c;
      vs_d2  <= vs_d1;
      sel_d2 <= hdmi_rowram_rddata[0];
    end
  end

  // Output pins: colour blanked outside the active region
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
    end else begin
      vga_r  <= act_d2 ? colour_c[23:16] : 8'h00;
      vga_g  <= act_d2 ? colour_c[15:8]  : 8'h00;
      vga_b  <= act_d2 ? colour_c[7:0]   : 8'h00;
      vga_hs <= hs_d2;
      vga_vs <= vs_d2;
      vga_de <= act_d2;
    end
  end

  // Row pacing and vblank pulses, registered one count early so they land on
  // the h==H_TOTAL-1 / h==0 positions themselves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowram_swap  <= 1'b0;
      next_row     <= '0;
      vblank_start <= 1'b0;
    end else begin
      rowram_swap  <= 1'b0;
      vblank_start <= (h == H_LAST) && (v == V_ACT_LAST);
      if (h == H_PRE_LAST) begin
        if (v[0] && (v <= V_SWAP_MAX)) begin
          rowram_swap <= 1'b1;
          next_row    <= odd_next_c;
        end else if (v == V_ROW0) begin
          rowram_swap <= 1'b1;
          next_row    <= 8'd0;
        end else if (v == V_LAST) begin
          rowram_swap <= 1'b1;
          next_row    <= 8'd1;
        end
      end
    end
  end

endmodule
